// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 receiver that tracks the single held game key (D, F, Space, J, K)
// and presents it as an 8-bit HID keycode in the pixel clock domain.
module ps2_keycode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       pixel_clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_strobe,
  output logic       frame_error
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Maps a Set-2 make code to its HID code; zero means "not a game key".
  function automatic logic [7:0] game_code(input logic [7:0] scan);
    case (scan)
      8'h23:   return 8'h07;
      8'h2B:   return 8'h09;
      8'h29:   return 8'h2C;
      8'h3B:   return 8'h0D;
      8'h42:   return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers, held at the idle-high level during reset
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;

  // NOTE: clocked state always uses non-blocking (<=) so every register sees
  // the pre-edge value of its neighbours, exactly like real flip-flops.
  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // ---------------------------------------------------------------------------
  // Falling-edge filter: one acceptance per low phase, after FILTER_LEN lows
  // ---------------------------------------------------------------------------
  logic [FW-1:0] low_cnt;
  logic          armed;
  logic          edge_ok;

  assign edge_ok = armed && !clk_s && (low_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      low_cnt <= '0;
      armed   <= 1'b1;
    end else if (clk_s) begin
      low_cnt <= '0;
      armed   <= 1'b1;
    end else begin
      if (edge_ok) begin
        armed <= 1'b0;
      end
      if (low_cnt != FW'(FILTER_LEN)) begin
        low_cnt <= low_cnt + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          byte_ok;
  logic          bad_frame;

  // An accepted edge always wins over the timeout in the same cycle.
  assign timeout = (state != S_IDLE) && !edge_ok &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default at the top, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (edge_ok) begin
      case (state)
        S_IDLE:   if (!data_s) state_next = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ok   = 1'b0;
    bad_frame = 1'b0;
    if (timeout) begin
      bad_frame = 1'b1;
    end else if (edge_ok) begin
      case (state)
        S_IDLE: bad_frame = data_s;
        S_STOP: begin
          byte_ok   = data_s && (^{shreg, par_bit});
          bad_frame = !byte_ok;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the shift register is reset too; it is a handful of flops, and a
  // known value keeps the parity check deterministic straight out of reset.
  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_IDLE || edge_ok) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (edge_ok) begin
        case (state)
          S_IDLE:   bitcnt <= '0;
          S_DATA: begin
            shreg[bitcnt] <= data_s;
            bitcnt        <= bitcnt + 3'd1;
          end
          S_PARITY: par_bit <= data_s;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scancode decoder and registered outputs
  // ---------------------------------------------------------------------------
  logic       brk;
  logic       ext;
  logic       brk_next;
  logic       ext_next;
  logic [7:0] keycode_next;
  logic       strobe_next;
  logic [7:0] mapped;

  assign mapped = game_code(shreg);

  always_comb begin
    keycode_next = keycode;
    strobe_next  = 1'b0;
    brk_next     = brk;
    ext_next     = ext;
    if (byte_ok) begin
      if (shreg == CODE_EXT) begin
        ext_next = 1'b1;
      end else if (shreg == CODE_BRK) begin
        brk_next = 1'b1;
      end else begin
        brk_next = 1'b0;
        ext_next = 1'b0;
        if (!ext && mapped != 8'h00) begin
          if (!brk) begin
            if (mapped != keycode) begin
              keycode_next = mapped;
              strobe_next  = 1'b1;
            end
          end else if (mapped == keycode) begin
            keycode_next = 8'h00;
          end
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode     <= 8'h00;
      key_strobe  <= 1'b0;
      frame_error <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
    end else begin
      keycode     <= keycode_next;
      key_strobe  <= strobe_next;
      frame_error <= bad_frame;
      brk         <= brk_next;
      ext         <= ext_next;
    end
  end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

Receives PS/2 Set-2 scancode frames from the keyboard connector and turns them into the 8-bit USB-HID-style `keycode` that the tile renderer consumes. It holds the code of the currently pressed game key (D, F, Space, J, K) and drives zero when no game key is held. It sits between the board PS/2 pins and the game/render logic, and runs in the pixel clock domain.

## Interface

**Parameters**
- `FILTER_LEN`, default 8: consecutive `pixel_clk` cycles the synchronized `ps2_clk` must stay low before a falling edge is accepted.
- `TIMEOUT_CYCLES`, default 50000: idle cycles allowed mid-frame before the frame is aborted (2 ms at 25 MHz).

**Ports**
- `pixel_clk` in 1: the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw keyboard clock. Asynchronous to `pixel_clk`, idles high.
- `ps2_data` in 1: raw keyboard data. Asynchronous to `pixel_clk`, idles high.
- `keycode` out 8: HID code of the held game key, otherwise 0x00.
- `key_strobe` out 1: one-cycle pulse whenever `keycode` changes to a nonzero value.
- `frame_error` out 1: one-cycle pulse on a parity error, bad start/stop bit, or timeout.

## Operation

**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- A falling edge is accepted when the synchronized clock has been high, then stays low for `FILTER_LEN` consecutive cycles. Only one acceptance is allowed per low phase.
- Data is sampled in the acceptance cycle.

**Frame FSM:** IDLE → DATA → PARITY → STOP → IDLE.
- IDLE: on an accepted edge with data=0 (start bit), go to DATA and set bitcnt=0. If data=1 on an accepted edge, pulse `frame_error` and stay in IDLE.
- DATA: shift the data bit into `shreg[bitcnt]` (LSB first). After bitcnt=7, go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: the byte is valid only if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A valid byte goes to the decoder. An invalid byte pulses `frame_error` and is dropped. Either way, return to IDLE.
- Timeout counter: cleared on every accepted edge and in IDLE. It counts in DATA, PARITY and STOP. When it reaches `TIMEOUT_CYCLES`, pulse `frame_error` and return to IDLE. A partial byte is never decoded.

**Decoder** (flags `brk`, `ext`; both 0 after reset)
- 0xE0 sets `ext`. 0xF0 sets `brk`. Neither changes `keycode`.
- Any other byte B is interpreted with the current flags, after which both flags clear.
  - If `ext`=1: B is ignored.
  - If B is not a game key: it is ignored.
- Map: 0x23→0x07 (D), 0x2B→0x09 (F), 0x29→0x2C (Space), 0x3B→0x0D (J), 0x42→0x0E (K).
- Make (`brk`=0) of a game key: `keycode` takes the mapped value, so the latest make wins. `key_strobe` pulses only if the value differs from the current `keycode`. Typematic repeats of the held key produce no strobe.
- Break (`brk`=1) of a game key: `keycode` clears to 0x00 only if the mapped value equals the current `keycode`. A break of any other key has no effect.
- A `frame_error` does not alter `brk`, `ext` or `keycode`.

## Timing
- **Reset values:** `keycode`=0x00, `key_strobe`=0, `frame_error`=0, FSM=IDLE, flags=0, synchronizers=1, timeout counter=0.
- Reset asserted mid-frame discards the partial byte immediately. After release, the next frame must begin with a fresh start bit.
- **Edge latency:** an accepted edge occurs 2 (sync) + `FILTER_LEN` cycles after the pin falls.
- **Output latency:** `keycode`, `key_strobe` and `frame_error` are registered. They update in the cycle after the stop-bit acceptance (or the timeout cycle).
- `key_strobe` and `frame_error` are exactly one cycle wide. They never assert in the same cycle.
- `keycode` is stable between updates and is safe to sample on any clock edge, including the `vs`-domain logic after synchronization downstream.
- **Glitch rejection:** a low pulse on `ps2_clk` shorter than `FILTER_LEN` cycles is ignored.

## Test plan
- **Make D:** frame 0x23 (parity 0, stop 1). Required: `keycode` goes 0x00→0x07 one cycle after the stop edge, with one `key_strobe` pulse.
- **Break D:** after a D make, send F0, 23. Required: `keycode`=0x00 and no strobe. Then send F0, 42 while J is held. Required: `keycode` stays 0x0D.
- **Rollover and repeats:** send make F, make K, make K. Required: `keycode` goes 0x09 then 0x0E, with exactly two strobes total.
- **Bad parity:** frame 0x29 with the parity bit inverted. Required: one `frame_error` pulse, `keycode` unchanged. The following correct 0x29 frame yields 0x2C with a strobe.
- **Timeout and glitches:** stop clocking after 4 data bits and wait `TIMEOUT_CYCLES`. Required: one `frame_error`, FSM back in IDLE, and the next full frame decodes correctly. Inject 3-cycle low glitches on `ps2_clk`. Required: no effect.
- **Extended keys and reset:** send E0, 23 (extended). Required: ignored. Send E0, F0, 23. Required: ignored, `brk`/`ext` cleared. Drive `Reset_n` low after 5 bits of a frame. Required: all outputs 0 immediately, and the subsequent frame decodes normally.
